// File: rtl/bsram_arbiter.sv
// Two-port arbiter for the cartridge backup RAM: port A (mapper/CPU) has priority,
// port B (save/load engine) is guaranteed service by a starvation counter.
module bsram_arbiter #(
    parameter int AW         = 20,
    parameter int DW         = 8,
    parameter int ACC_CYC    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic [AW-1:0] bsram_mask,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_d,
    output logic          a_ack,
    output logic [DW-1:0] a_q,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_d,
    output logic          b_ack,
    output logic [DW-1:0] b_q,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,
    output logic          mem_ce_n,
    output logic          mem_oe_n,
    output logic          mem_we_n,
    output logic [1:0]    grant
);

    localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(ACC_CYC - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] starve, starve_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] d_nxt;
    logic          ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic [1:0]    grant_nxt;
    logic          a_ack_nxt, b_ack_nxt;
    logic [DW-1:0] a_q_nxt, b_q_nxt;
    logic          pick_b;

    // B wins only when A is absent or A has taken STARVE_MAX turns while B waited
    assign pick_b = b_req && (!a_req || (starve == STARVE_TOP));

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        starve_nxt = starve;
        addr_nxt   = mem_addr;
        d_nxt      = mem_d;
        ce_n_nxt   = mem_ce_n;
        oe_n_nxt   = mem_oe_n;
        we_n_nxt   = mem_we_n;
        grant_nxt  = grant;
        a_ack_nxt  = 1'b0;
        b_ack_nxt  = 1'b0;
        a_q_nxt    = a_q;
        b_q_nxt    = b_q;

        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_LOAD;
                    ce_n_nxt  = 1'b0;
                    if (pick_b) begin
                        addr_nxt   = b_addr & bsram_mask;
                        d_nxt      = b_d;
                        oe_n_nxt   = b_we;
                        we_n_nxt   = !b_we;
                        grant_nxt  = 2'b10;
                        starve_nxt = '0;
                    end else begin
                        addr_nxt  = a_addr & bsram_mask;
                        d_nxt     = a_d;
                        oe_n_nxt  = a_we;
                        we_n_nxt  = !a_we;
                        grant_nxt = 2'b01;
                        if (b_req && (starve != STARVE_TOP)) begin
                            starve_nxt = starve + SW'(1);
                        end
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    // oe_n low identifies a read; mem_q is valid on this last cycle
                    if (!mem_oe_n) begin
                        if (grant[1]) begin
                            b_q_nxt = mem_q;
                        end else begin
                            a_q_nxt = mem_q;
                        end
                    end
                    ce_n_nxt  = 1'b1;
                    oe_n_nxt  = 1'b1;
                    we_n_nxt  = 1'b1;
                    a_ack_nxt = grant[0];
                    b_ack_nxt = grant[1];
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            starve   <= '0;
            mem_addr <= '0;
            mem_d    <= '0;
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            grant    <= 2'b00;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            cnt      <= cnt_nxt;
            starve   <= starve_nxt;
            mem_addr <= addr_nxt;
            mem_d    <= d_nxt;
            mem_ce_n <= ce_n_nxt;
            mem_oe_n <= oe_n_nxt;
            mem_we_n <= we_n_nxt;
            grant    <= grant_nxt;
            a_ack    <= a_ack_nxt;
            b_ack    <= b_ack_nxt;
            a_q      <= a_q_nxt;
            b_q      <= b_q_nxt;
        end
    end

endmodule
